serial_recv: RTL and testbench

//  Receive end of the 2-bit/CLKS LVDS DDR serial link. Takes the pair stream (already split by an

---
 rtl/serial_link_pkg.sv | 13 +
 rtl/serial_recv_if.sv | 11 +
 rtl/serial_recv_align.sv | 66 ++++++
 rtl/serial_recv.sv | 45 ++++
 tb/tb_serial_recv.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: constants and FSM state type shared by both ends of the serial link
// SL_HX is the extra history bit used for the one-bit-slipped window (SERIAL_RECV_PHASE_SWAP_EN).
package serial_link_pkg;
  localparam int SL_DW = 64;
  localparam logic [63:0] SL_TRAIN_WORD = 64'hA5C3_0FF0_5A3C_96E1;
  localparam int SL_LOCK_CNT = 4;
`ifdef SERIAL_RECV_PHASE_SWAP_EN
  localparam int SL_HX = 1;
`else
  localparam int SL_HX = 0;
`endif
  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;
endpackage

// File: rtl/serial_recv_if.sv
// serial_recv_if: bit-pair input, relock request and received-word outputs of the link receiver
interface serial_recv_if import serial_link_pkg::*; #(parameter int DW = SL_DW) ();
  logic [1:0] DIN;
  logic RELOCK;
  logic [DW-1:0] DOUT;
  logic DOUT_VALID;
  logic LOCKED;
  logic PHASE;
  modport master (output DIN, RELOCK, input DOUT, DOUT_VALID, LOCKED, PHASE);
  modport slave (input DIN, RELOCK, output DOUT, DOUT_VALID, LOCKED, PHASE);
endinterface

// File: rtl/serial_recv_align.sv
// serial_recv_align: training-word window compare, HUNT/VERIFY/LOCK FSM and match counter
// SERIAL_RECV_PHASE_SWAP_EN adds the one-bit-slipped window W1 as a HUNT candidate.
module serial_recv_align import serial_link_pkg::*; #(
  parameter int DW = SL_DW,
  parameter logic [DW-1:0] TRAIN_WORD = DW'(SL_TRAIN_WORD),
  parameter int LOCK_CNT = SL_LOCK_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DW+SL_HX-1:0] hist,
  input  logic boundary,
  input  logic relock,
  output logic [DW-1:0] win,
  output logic locked,
  output logic phase,
  output logic restart,
  output logic deliver
);
  state_t state, state_nx;
  logic [3:0] mcnt, mcnt_nx;
  logic phase_nx, hit0, hit1, drop, good;
  assign hit0 = hist[DW-1:0] == TRAIN_WORD;
`ifdef SERIAL_RECV_PHASE_SWAP_EN
  assign hit1 = hist[DW:1] == TRAIN_WORD;
  assign win = phase ? hist[DW:1] : hist[DW-1:0];
`else
  assign hit1 = 1'b0;
  assign win = hist;
`endif
  assign good = win == TRAIN_WORD;
  // relock while hunting changes nothing, so a simultaneous match still counts
  assign drop = relock && state != HUNT;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= HUNT;
      mcnt <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      mcnt <= mcnt_nx;
      phase <= phase_nx;
    end
  always_comb begin
    state_nx = state;
    mcnt_nx = mcnt;
    phase_nx = phase;
    if (drop) begin
      state_nx = HUNT;
      mcnt_nx = '0;
      phase_nx = 1'b0;
    end else if (state == HUNT && (hit0 || hit1)) begin
      state_nx = LOCK_CNT == 1 ? LOCK : VERIFY;
      mcnt_nx = 4'd1;
      phase_nx = !hit0;
    end else if (state == VERIFY && boundary) begin
      state_nx = !good ? HUNT : (mcnt + 4'd1 == 4'(LOCK_CNT) ? LOCK : VERIFY);
      mcnt_nx = good ? mcnt + 4'd1 : '0;
      phase_nx = good && phase;
    end
  end
  always_comb begin
    locked = state == LOCK;
    restart = state == HUNT && (hit0 || hit1);
    deliver = state == LOCK && boundary && !relock;
  end
endmodule

// File: rtl/serial_recv.sv
// serial_recv: DDR bit-pair deserialiser with training-word alignment and per-word valid strobe
// Optional SERIAL_RECV_PHASE_SWAP_EN: also align on a one-bit-slipped window (PHASE=1).
module serial_recv import serial_link_pkg::*; #(
  parameter int DW = SL_DW,
  parameter logic [DW-1:0] TRAIN_WORD = DW'(SL_TRAIN_WORD),
  parameter int LOCK_CNT = SL_LOCK_CNT
) (
  input logic CLKS,
  input logic RSTXS,
  serial_recv_if.slave bus
);
  localparam int HW = DW + SL_HX;
  localparam int CW = $clog2(DW / 2);
  logic [HW-1:0] hist;
  logic [CW-1:0] cnt;
  logic [DW-1:0] win, dout;
  logic dout_valid, boundary, restart, deliver;
  assign boundary = cnt == CW'(DW / 2 - 1);
  always_ff @(posedge CLKS)
    if (!RSTXS) begin
      hist <= '0;
      cnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      hist <= {hist[HW-3:0], bus.DIN};
      cnt <= restart || boundary ? '0 : cnt + CW'(1);
      dout <= deliver ? win : dout;
      dout_valid <= deliver;
    end
  serial_recv_align #(.DW(DW), .TRAIN_WORD(TRAIN_WORD), .LOCK_CNT(LOCK_CNT)) u_align (
    .clk(CLKS),
    .rst_n(RSTXS),
    .hist(hist),
    .boundary(boundary),
    .relock(bus.RELOCK),
    .win(win),
    .locked(bus.LOCKED),
    .phase(bus.PHASE),
    .restart(restart),
    .deliver(deliver)
  );
  assign bus.DOUT = dout;
  assign bus.DOUT_VALID = dout_valid;
endmodule

// File: tb/tb_serial_recv.sv
// tb_serial_recv: bit-stream reference model checked every cycle, plus hand-timed lock/strobe points
module tb_serial_recv;
  import serial_link_pkg::*;
  localparam int DW = 64;
  localparam int LC = 4;
  localparam logic [63:0] T = SL_TRAIN_WORD;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D2 = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
  logic CLKS = 1'b0;
  logic RSTXS = 1'b0;
  serial_recv_if #(.DW(DW)) bus ();
  serial_recv #(.DW(DW), .TRAIN_WORD(T), .LOCK_CNT(LC)) dut (.CLKS(CLKS), .RSTXS(RSTXS), .bus(bus.slave));
  always #5 CLKS = ~CLKS;

  int vectors = 0, miscompares = 0, cyc = 0, s_cyc = 0;
  bit mq[$], txq[$];
  int mode = 0, mc = 0, nend = 0;
  logic ph = 1'b0, e_valid = 1'b0, prev_locked = 1'b0;
  logic [63:0] e_dout = '0;
  int rises[$], strb[$];
  logic [63:0] strbd[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // the 64 bits received most recently (off=0) or ending one bit earlier (off=1), zeros before reset
  function automatic logic [63:0] window(int off);
    logic [63:0] w;
    int n;
    n = mq.size();
    for (int k = 0; k < 64; k++) w[k] = (n - 1 - off - k) >= 0 ? mq[n - 1 - off - k] : 1'b0;
    return w;
  endfunction

  // model: mode 0 hunt, 1 verify, 2 lock; frames end every 64 received bits after the match point
  task automatic model_step();
    logic [63:0] a;
    cyc++;
    e_valid = 1'b0;
    if (!RSTXS) begin
      mq.delete();
      mode = 0; mc = 0; ph = 1'b0; e_dout = '0;
    end else begin
      a = ph ? window(1) : window(0);
      if (mode != 0 && bus.RELOCK) begin
        mode = 0; mc = 0; ph = 1'b0;
      end else if (mode == 0) begin
        if (window(0) == T) begin
          mode = 1; mc = 1; ph = 1'b0; nend = mq.size() + 64;
        end
`ifdef SERIAL_RECV_PHASE_SWAP_EN
        else if (window(1) == T) begin
          mode = 1; mc = 1; ph = 1'b1; nend = mq.size() + 64;
        end
`endif
      end else if (mq.size() == nend) begin
        nend += 64;
        if (mode == 2) begin
          e_dout = a; e_valid = 1'b1;
        end else if (a == T) begin
          mc++;
          if (mc == LC) mode = 2;
        end else begin
          mode = 0; mc = 0; ph = 1'b0;
        end
      end
      mq.push_back(bus.DIN[1]);
      mq.push_back(bus.DIN[0]);
    end
  endtask

  initial forever begin
    @(posedge CLKS);
    model_step();
  end

  initial forever begin
    @(negedge CLKS);
    chk("DOUT", bus.DOUT, e_dout);
    chk("DOUT_VALID", 64'(bus.DOUT_VALID), 64'(e_valid));
    chk("LOCKED", 64'(bus.LOCKED), 64'(mode == 2));
    chk("PHASE", 64'(bus.PHASE), 64'(ph));
    if (bus.LOCKED === 1'b1 && !prev_locked) rises.push_back(cyc);
    prev_locked = bus.LOCKED === 1'b1;
    if (bus.DOUT_VALID === 1'b1) begin
      strb.push_back(cyc);
      strbd.push_back(bus.DOUT);
    end
  end

  function automatic int rat(int i); return i < rises.size() ? rises[i] - s_cyc : -1; endfunction
  function automatic int sat(int i); return i < strb.size() ? strb[i] - s_cyc : -1; endfunction
  function automatic logic [63:0] dat(int i); return i < strbd.size() ? strbd[i] : 64'hx; endfunction

  task automatic qw(input logic [63:0] w);
    for (int k = 63; k >= 0; k--) txq.push_back(w[k]);
  endtask

  task automatic run(input int n);
    bit b1, b0;
    repeat (n) begin
      b1 = txq.size() > 0 ? txq.pop_front() : 1'b0;
      b0 = txq.size() > 0 ? txq.pop_front() : 1'b0;
      bus.DIN = {b1, b0};
      @(negedge CLKS);
    end
  endtask

  task automatic do_reset(input int n);
    RSTXS = 1'b0;
    repeat (n) begin
      bus.DIN = 2'($urandom);
      @(negedge CLKS);
    end
    RSTXS = 1'b1;
    txq.delete();
  endtask

  task automatic start();
    rises.delete();
    strb.delete();
    strbd.delete();
    s_cyc = cyc + 1;
  endtask

  initial begin
    bus.DIN = 2'b00;
    bus.RELOCK = 1'b0;
    // 1: reset with random input, then idle zeros
    do_reset(5);
    start();
    run(100);
    chk("t1_locked", 64'(bus.LOCKED), 64'd0);
    chk("t1_strobes", 64'(strb.size()), 64'd0);
    // 2: four aligned training words then data
    start();
    repeat (4) qw(T);
    qw(D0); qw(D1); qw(D2);
    run(32 * 7 + 4);
    chk("t2_lock_cyc", 64'(rat(0)), 64'd128);
    chk("t2_first_strobe", 64'(sat(0)), 64'd160);
    chk("t2_dout0", dat(0), D0);
    chk("t2_dout1", dat(1), D1);
    chk("t2_period", 64'(sat(2) - sat(1)), 64'd32);
    chk("t2_strobes", 64'(strb.size()), 64'd3);
    // 5: relock on a boundary cycle
    do_reset(1);
    run(10);
    start();
    repeat (4) qw(T);
    qw(D0); qw(D1);
    repeat (4) qw(T);
    qw(D2);
    run(192);
    bus.RELOCK = 1'b1;
    run(1);
    bus.RELOCK = 1'b0;
    chk("t5_locked_drop", 64'(bus.LOCKED), 64'd0);
    run(163);
    chk("t5_strobes", 64'(strb.size()), 64'd2);
    chk("t5_strobe0", 64'(sat(0)), 64'd160);
    chk("t5_strobe1", 64'(sat(1)), 64'd352);
    chk("t5_dout1", dat(1), D2);
    chk("t5_relock_cyc", 64'(rat(1)), 64'd320);
    // 3: bad frame during verify forces a fresh hunt
    do_reset(1);
    run(10);
    start();
    qw(T); qw(T); qw(FF);
    repeat (4) qw(T);
    qw(D0);
    run(32 * 8 + 4);
    chk("t3_lock_cyc", 64'(rat(0)), 64'd224);
    chk("t3_strobes", 64'(strb.size()), 64'd1);
    chk("t3_strobe0", 64'(sat(0)), 64'd256);
    chk("t3_dout0", dat(0), D0);
    // 4: stream slipped by one bit
    do_reset(1);
    run(10);
    start();
    txq.push_back(1'b0);
    repeat (4) qw(T);
    qw(D0); qw(D1);
    run(32 * 6 + 4);
`ifdef SERIAL_RECV_PHASE_SWAP_EN
    chk("t4_lock_cyc", 64'(rat(0)), 64'd129);
    chk("t4_phase", 64'(bus.PHASE), 64'd1);
    chk("t4_strobe0", 64'(sat(0)), 64'd161);
    chk("t4_dout0", dat(0), D0);
    chk("t4_dout1", dat(1), D1);
`else
    chk("t4_rises", 64'(rises.size()), 64'd0);
    chk("t4_strobes", 64'(strb.size()), 64'd0);
    chk("t4_locked", 64'(bus.LOCKED), 64'd0);
`endif
    // 6: one-cycle reset mid-frame while locked
    do_reset(1);
    run(10);
    start();
    repeat (4) qw(T);
    qw(D0);
    run(140);
    chk("t6_locked_before", 64'(bus.LOCKED), 64'd1);
    do_reset(1);
    chk("t6_dout", bus.DOUT, 64'd0);
    chk("t6_valid", 64'(bus.DOUT_VALID), 64'd0);
    chk("t6_locked", 64'(bus.LOCKED), 64'd0);
    run(10);
    start();
    repeat (4) qw(T);
    qw(D2);
    run(32 * 5 + 4);
    chk("t6_lock_cyc", 64'(rat(0)), 64'd128);
    chk("t6_strobes", 64'(strb.size()), 64'd1);
    chk("t6_dout", dat(0), D2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
